// File: rtl/adc_sample_assembler_if.sv
// Stream bundle around the sample assembler: 8-bit byte stream in, 16-bit tagged sample stream out.
// The master modport is the surrounding environment and the slave modport is the assembler.
interface adc_sample_assembler_if #(
   parameter int CH_W = 8
);
   logic [7:0]      s_axis_tdata;
   logic            s_axis_tvalid;
   logic            s_axis_tready;
   logic [15:0]     m_axis_tdata;
   logic [CH_W-1:0] m_axis_tuser;
   logic            m_axis_tlast;
   logic            m_axis_tvalid;
   logic            m_axis_tready;

   modport master (
      output s_axis_tdata,
      output s_axis_tvalid,
      input  s_axis_tready,
      input  m_axis_tdata,
      input  m_axis_tuser,
      input  m_axis_tlast,
      input  m_axis_tvalid,
      output m_axis_tready
   );

   modport slave (
      input  s_axis_tdata,
      input  s_axis_tvalid,
      output s_axis_tready,
      output m_axis_tdata,
      output m_axis_tuser,
      output m_axis_tlast,
      output m_axis_tvalid,
      input  m_axis_tready
   );
endinterface

// File: rtl/adc_sample_assembler.sv
// Packs SPI ADC bytes into samples, extracts the sample field, tags each with a round-robin
// channel index and flags the last channel of a frame; counts completed frames.
module adc_sample_assembler #(
   parameter int BYTES_PER_SAMPLE = 2,
   parameter int SAMPLE_BITS      = 12,
   parameter int SAMPLE_SHIFT     = 0,
   parameter int NUM_CHANNELS     = 8,
   parameter int MSB_FIRST        = 1,
   parameter int CH_W             = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   adc_sample_assembler_if.slave bus,
   output logic [15:0]          frame_count,
   output logic                 busy
);
   localparam int RAW_W = 8 * BYTES_PER_SAMPLE;
   localparam int BC_W  = 2;
   localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES_PER_SAMPLE - 1);
   localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_CHANNELS - 1);

   logic [BC_W-1:0]  byte_cnt_reg;
   logic [CH_W-1:0]  ch_cnt_reg;
   logic [RAW_W-1:0] raw_reg;
   logic [RAW_W-1:0] raw_next;
   logic [15:0]      sample_next;
   logic [15:0]      tdata_reg;
   logic [CH_W-1:0]  tuser_reg;
   logic             tlast_reg;
   logic             tvalid_reg;
   logic [15:0]      frame_reg;

   logic last_byte;
   logic s_ready;
   logic byte_accept;
   logic out_accept;

   // Only the byte that completes a sample needs somewhere to go, so only it can stall.
   assign last_byte   = (byte_cnt_reg == LAST_BYTE);
   assign s_ready     = !rst && (!enable || !last_byte || !tvalid_reg || bus.m_axis_tready);
   assign byte_accept = bus.s_axis_tvalid && s_ready;
   assign out_accept  = tvalid_reg && bus.m_axis_tready;

   generate
      if (RAW_W == 8) begin : g_raw_single
         assign raw_next = bus.s_axis_tdata;
      end else if (MSB_FIRST != 0) begin : g_raw_msb
         assign raw_next = {raw_reg[RAW_W-9:0], bus.s_axis_tdata};
      end else begin : g_raw_lsb
         assign raw_next = {bus.s_axis_tdata, raw_reg[RAW_W-1:8]};
      end
   endgenerate

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_field
         if (gi < SAMPLE_BITS) begin : g_bit
            assign sample_next[gi] = raw_next[SAMPLE_SHIFT + gi];
         end else begin : g_zero
            assign sample_next[gi] = 1'b0;
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt_reg <= '0;
         ch_cnt_reg   <= '0;
         raw_reg      <= '0;
         tdata_reg    <= '0;
         tuser_reg    <= '0;
         tlast_reg    <= 1'b0;
         tvalid_reg   <= 1'b0;
         frame_reg    <= '0;
      end else begin
         if (out_accept) begin
            tvalid_reg <= 1'b0;
            if (tlast_reg) begin
               frame_reg <= frame_reg + 16'd1;
            end
         end
         // While disabled the byte stream is drained and dropped; the output register still drains.
         if (!enable) begin
            byte_cnt_reg <= '0;
            ch_cnt_reg   <= '0;
            raw_reg      <= '0;
         end else if (byte_accept) begin
            raw_reg <= raw_next;
            if (last_byte) begin
               byte_cnt_reg <= '0;
               tdata_reg    <= sample_next;
               tuser_reg    <= ch_cnt_reg;
               tlast_reg    <= (ch_cnt_reg == LAST_CH);
               tvalid_reg   <= 1'b1;
               if (ch_cnt_reg == LAST_CH) begin
                  ch_cnt_reg <= '0;
               end else begin
                  ch_cnt_reg <= ch_cnt_reg + CH_W'(1);
               end
            end else begin
               byte_cnt_reg <= byte_cnt_reg + BC_W'(1);
            end
         end
      end
   end

   assign bus.s_axis_tready = s_ready;
   assign bus.m_axis_tdata  = tdata_reg;
   assign bus.m_axis_tuser  = tuser_reg;
   assign bus.m_axis_tlast  = tlast_reg;
   assign bus.m_axis_tvalid = tvalid_reg;
   assign frame_count       = frame_reg;
   assign busy              = (byte_cnt_reg != '0) || tvalid_reg;
endmodule
